// File: rtl/alu_ctrl_seq.sv
// rtl/alu_ctrl_seq.sv - registered ALU control sequencer with multi-cycle mul back-pressure
module alu_ctrl_seq #(
    parameter int CTRL_W  = 4,
    parameter int MUL_LAT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        aluop,
    input  logic [5:0]        funct,
    input  logic              flush,
    output logic              out_valid,
    output logic [CTRL_W-1:0] alucontrol,
    output logic              multi,
    output logic              last,
    output logic              illegal
);

    localparam int CNT_W = $clog2(MUL_LAT + 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_MULTI = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_valid;
    logic              w_valid_nxt;
    logic [CTRL_W-1:0] r_ctrl;
    logic [CTRL_W-1:0] w_ctrl_nxt;
    logic              r_multi;
    logic              w_multi_nxt;
    logic              r_last;
    logic              w_last_nxt;
    logic              r_illegal;
    logic              w_illegal_nxt;

    logic [3:0]        w_code;
    logic              w_is_mul;
    logic              w_is_illegal;

    // Decode of the operation currently presented by the decoder
    always_comb begin
        w_code       = 4'h0;
        w_is_mul     = 1'b0;
        w_is_illegal = 1'b0;
        case (aluop)
            2'b01: w_code = 4'h2;
            2'b11: w_code = 4'h0;
            2'b10: w_code = 4'h3;
            default: begin
                if (funct == 6'b001000) begin
                    w_code = 4'h7;
                end else if (funct == 6'b110111) begin
                    w_code   = 4'h6;
                    w_is_mul = 1'b1;
                end else begin
                    w_is_illegal = 1'b1;
                end
            end
        endcase
    end

    // Next-state and next-output logic; everything holds unless changed below
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_valid_nxt   = r_valid;
        w_ctrl_nxt    = r_ctrl;
        w_multi_nxt   = r_multi;
        w_last_nxt    = r_last;
        w_illegal_nxt = r_illegal;
        if (flush) begin
            // Flush beats any pending accept and clears the op in flight
            w_state_nxt   = S_IDLE;
            w_cnt_nxt     = '0;
            w_valid_nxt   = 1'b0;
            w_multi_nxt   = 1'b0;
            w_last_nxt    = 1'b0;
            w_illegal_nxt = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        w_valid_nxt   = 1'b1;
                        w_ctrl_nxt    = CTRL_W'(w_code);
                        w_illegal_nxt = w_is_illegal;
                        w_multi_nxt   = w_is_mul;
                        if (w_is_mul && (MUL_LAT > 1)) begin
                            w_last_nxt  = 1'b0;
                            w_cnt_nxt   = CNT_W'(MUL_LAT - 1);
                            w_state_nxt = S_MULTI;
                        end else begin
                            w_last_nxt = 1'b1;
                        end
                    end else begin
                        w_valid_nxt   = 1'b0;
                        w_multi_nxt   = 1'b0;
                        w_last_nxt    = 1'b0;
                        w_illegal_nxt = 1'b0;
                    end
                end
                default: begin
                    // Code/multi/valid hold; leaving on cnt==1 makes the next
                    // cycle the last one and reopens in_ready for back-to-back ops
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_nxt = S_IDLE;
                        w_last_nxt  = 1'b1;
                    end
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_valid   <= 1'b0;
            r_ctrl    <= '0;
            r_multi   <= 1'b0;
            r_last    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_valid   <= w_valid_nxt;
            r_ctrl    <= w_ctrl_nxt;
            r_multi   <= w_multi_nxt;
            r_last    <= w_last_nxt;
            r_illegal <= w_illegal_nxt;
        end
    end

    assign in_ready   = (r_state == S_IDLE);
    assign out_valid  = r_valid;
    assign alucontrol = r_ctrl;
    assign multi      = r_multi;
    assign last       = r_last;
    assign illegal    = r_illegal;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb/tb_alu_ctrl_seq.sv - self-checking bench for alu_ctrl_seq (MUL_LAT 3, 4 and 1/CTRL_W 6 builds)
module tb_alu_ctrl_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [1:0] aluop;
    logic [5:0] funct;
    logic       flush;

    logic       rdy  [3];
    logic       ov   [3];
    logic       mlt  [3];
    logic       lst  [3];
    logic       ill  [3];
    logic [3:0] ctrl0;
    logic [3:0] ctrl1;
    logic [5:0] ctrl2;
    logic [5:0] ctrl_a [3];

    int total = 0;
    int bad   = 0;

    // Reference model: remaining output cycles of the current op
    int         lat    [3] = '{3, 4, 1};
    int         m_rem  [3];
    logic [5:0] m_code [3];
    logic       m_mul  [3];
    logic       m_ill  [3];

    alu_ctrl_seq #(.CTRL_W(4), .MUL_LAT(3)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
        .aluop(aluop), .funct(funct), .flush(flush), .out_valid(ov[0]),
        .alucontrol(ctrl0), .multi(mlt[0]), .last(lst[0]), .illegal(ill[0])
    );
    alu_ctrl_seq #(.CTRL_W(4), .MUL_LAT(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
        .aluop(aluop), .funct(funct), .flush(flush), .out_valid(ov[1]),
        .alucontrol(ctrl1), .multi(mlt[1]), .last(lst[1]), .illegal(ill[1])
    );
    alu_ctrl_seq #(.CTRL_W(6), .MUL_LAT(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]),
        .aluop(aluop), .funct(funct), .flush(flush), .out_valid(ov[2]),
        .alucontrol(ctrl2), .multi(mlt[2]), .last(lst[2]), .illegal(ill[2])
    );

    assign ctrl_a[0] = {2'b00, ctrl0};
    assign ctrl_a[1] = {2'b00, ctrl1};
    assign ctrl_a[2] = ctrl2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int k, input logic [5:0] obs, input logic [5:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_rem[k]  = 0;
            m_code[k] = 6'h0;
            m_mul[k]  = 1'b0;
            m_ill[k]  = 1'b0;
        end
    endtask

    task automatic model_edge();
        logic [5:0] c;
        logic       is_mul;
        logic       is_ill;
        c      = 6'h0;
        is_mul = 1'b0;
        is_ill = 1'b0;
        if (aluop == 2'b01)      c = 6'd2;
        else if (aluop == 2'b10) c = 6'd3;
        else if (aluop == 2'b00) begin
            if (funct == 6'd8)       c = 6'd7;
            else if (funct == 6'd55) begin c = 6'd6; is_mul = 1'b1; end
            else                     is_ill = 1'b1;
        end
        for (int k = 0; k < 3; k++) begin
            if (flush) begin
                m_rem[k] = 0;
            end else if (in_valid && m_rem[k] <= 1) begin
                m_code[k] = c;
                m_mul[k]  = is_mul;
                m_ill[k]  = is_ill;
                m_rem[k]  = is_mul ? lat[k] : 1;
            end else if (m_rem[k] > 0) begin
                m_rem[k]--;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            chk("in_ready",   k, {5'b0, rdy[k]}, {5'b0, m_rem[k] <= 1});
            chk("out_valid",  k, {5'b0, ov[k]},  {5'b0, m_rem[k] > 0});
            chk("last",       k, {5'b0, lst[k]}, {5'b0, m_rem[k] == 1});
            chk("multi",      k, {5'b0, mlt[k]}, {5'b0, (m_rem[k] > 0) && m_mul[k]});
            chk("illegal",    k, {5'b0, ill[k]}, {5'b0, (m_rem[k] > 0) && m_ill[k]});
            chk("alucontrol", k, ctrl_a[k], m_code[k]);
        end
    endtask

    task automatic step(input logic v, input logic [1:0] op, input logic [5:0] f, input logic fl);
        in_valid = v;
        aluop    = op;
        funct    = f;
        flush    = fl;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        aluop    = 2'b00;
        funct    = 6'h0;
        flush    = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_all();
        #3 rst_n = 1'b1;

        // Back-to-back single-cycle ops
        step(1'b1, 2'b01, 6'h00, 1'b0);
        chk("lw_code", 0, ctrl_a[0], 6'd2);
        step(1'b1, 2'b11, 6'h00, 1'b0);
        chk("lui_code", 0, ctrl_a[0], 6'd0);
        step(1'b1, 2'b10, 6'h00, 1'b0);
        chk("ori_code", 0, ctrl_a[0], 6'd3);
        step(1'b0, 2'b00, 6'h00, 1'b0);

        // mul followed by a held jr
        step(1'b1, 2'b00, 6'b110111, 1'b0);
        chk("mul_code", 0, ctrl_a[0], 6'd6);
        chk("mul6_code", 2, ctrl_a[2], 6'h06);
        step(1'b1, 2'b00, 6'b001000, 1'b0);
        step(1'b1, 2'b00, 6'b001000, 1'b0);
        chk("mul_last", 0, {5'b0, lst[0]}, 6'd1);
        step(1'b1, 2'b00, 6'b001000, 1'b0);
        chk("jr_code", 0, ctrl_a[0], 6'd7);
        step(1'b0, 2'b00, 6'h00, 1'b0);
        step(1'b0, 2'b00, 6'h00, 1'b0);

        // Illegal funct, then funct ignored for non-R class
        step(1'b1, 2'b00, 6'b100000, 1'b0);
        chk("illegal_set", 0, {5'b0, ill[0]}, 6'd1);
        step(1'b1, 2'b01, 6'b100000, 1'b0);
        chk("illegal_clr", 0, {5'b0, ill[0]}, 6'd0);
        step(1'b0, 2'b00, 6'h00, 1'b0);

        // Flush in cycle 2 of a mul with a competing input
        step(1'b1, 2'b00, 6'b110111, 1'b0);
        step(1'b1, 2'b00, 6'b001000, 1'b1);
        chk("flush_ov", 1, {5'b0, ov[1]}, 6'd0);
        step(1'b0, 2'b00, 6'h00, 1'b0);

        // Asynchronous reset mid-mul
        step(1'b1, 2'b00, 6'b110111, 1'b0);
        step(1'b0, 2'b00, 6'h00, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #2 rst_n = 1'b1;
        step(1'b1, 2'b10, 6'h00, 1'b0);
        chk("post_rst_ori", 0, ctrl_a[0], 6'd3);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [1:0] op;
            logic [5:0] f;
            int         sel;
            op  = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 3);
            if (sel == 0)      f = 6'b110111;
            else if (sel == 1) f = 6'b001000;
            else               f = 6'($urandom);
            step(1'($urandom_range(0, 3) != 0), op, f, 1'($urandom_range(0, 15) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_seq.md
# alu_ctrl_seq

Parametrised, registered ALU control sequencer for the MIPS datapath, between the main decoder (`aluop`, `funct`) and the ALU. It decodes each accepted operation into an ALU control code one cycle after acceptance. Multi-cycle operations (`mul`) hold the code stable for `MUL_LAT` cycles and back-pressure the decoder through a ready/valid handshake. Unknown encodings are flagged instead of holding a stale code.

## Interface
- `CTRL_W`, default 4: ALU control width, must be ≥ 4; bits above [3:0] always 0.
- `MUL_LAT`, default 3: cycles a `mul` occupies the ALU, must be ≥ 1.
- `clk` input 1: single clock, all state updates on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: decoder presents an operation.
- `in_ready` output 1: block can accept; transfer happens when `in_valid && in_ready` at a rising edge.
- `aluop` input 2: class from the main decoder.
- `funct` input 6: R-type function field; used only when `aluop == 2'b00`.
- `flush` input 1: synchronous abort (pipeline flush / exception).
- `out_valid` output 1: `alucontrol` is valid for the ALU this cycle.
- `alucontrol` output CTRL_W: registered ALU control code.
- `multi` output 1: current output belongs to a multi-cycle op.
- `last` output 1: final valid cycle of the current op.
- `illegal` output 1: accepted op had an unknown encoding; registered alongside `out_valid`.

## Operation
- Decode, evaluated on accepted inputs only:
  - `aluop` 01 gives 4'h2 (lw/sw add).
  - `aluop` 11 gives 4'h0 (lui).
  - `aluop` 10 gives 4'h3 (ori).
  - `aluop` 00 with `funct` 001000 gives 4'h7 (jr).
  - `aluop` 00 with `funct` 110111 gives 4'h6 (mul, multi-cycle).
  - `aluop` 00 with any other `funct` gives 4'h0 with `illegal` = 1.
- Codes are zero-extended to CTRL_W.
- FSM states:
  - IDLE: `in_ready` = 1.
  - MULTI: `in_ready` = 0.
- In IDLE, on accept of a single-cycle op:
  - Next cycle: `out_valid` = 1, `last` = 1, `multi` = 0, `alucontrol` = code.
  - Remain in IDLE.
- In IDLE, on accept of `mul`:
  - Next cycle: `out_valid` = 1, `multi` = 1, code 4'h6.
  - If `MUL_LAT` == 1, behaves exactly as single-cycle except `multi` = 1; remain in IDLE.
  - Otherwise, load down-counter `cnt` = `MUL_LAT`-1 and go to MULTI. `cnt` width is `$clog2(MUL_LAT+1)`.
- In MULTI:
  - Each cycle `cnt` decrements.
  - `alucontrol`, `multi` and `out_valid` hold.
  - When `cnt` == 1 at a rising edge, next state is IDLE.
  - In the cycle after that edge, `last` = 1 and `in_ready` = 1. This allows back-to-back acceptance with no bubble.
- Without a new accept, `out_valid`, `last`, `multi` and `illegal` drop to 0 the cycle after the op's last cycle. `alucontrol` keeps its last value (not required to be 0).
- `flush`:
  - At a rising edge, any state goes to IDLE, `cnt` = 0, and `out_valid`, `last`, `multi` and `illegal` = 0 next cycle.
  - `flush` and `in_valid` in the same cycle: flush wins, nothing is accepted.
  - `in_ready` is not gated combinationally by `flush`.
- `in_valid` while `in_ready` = 0: ignored. The decoder must hold its inputs until accepted.
- `funct` is ignored when `aluop` != 00 and never raises `illegal` then.

## Timing
- Reset (`rst_n` low, asynchronous):
  - State IDLE, `cnt` = 0.
  - `alucontrol` = 0, `out_valid` = 0, `multi` = 0, `last` = 0, `illegal` = 0.
  - `in_ready` = 1 once reset is released.
- Reset asserted mid-MULTI aborts immediately. No output is held.
- Latency: accept edge N gives `out_valid` in cycle N+1.
  - Single-cycle ops: valid 1 cycle.
  - `mul`: valid cycles N+1 … N+`MUL_LAT`, with `last` in cycle N+`MUL_LAT`.
- Throughput: one single-cycle op per cycle; one `mul` per `MUL_LAT` cycles.
- `in_ready` is a registered function of state only. There is no combinational path from `in_valid` to `in_ready`.
- All outputs are registered.

## Test plan
- Reset, then `aluop` 01, 11, 10 on three consecutive cycles with `in_valid` = 1: `alucontrol` = 2, 0, 3 in cycles 1–3; `out_valid` = 1 and `last` = 1 each cycle; `in_ready` never drops.
- `MUL_LAT` = 3, accept `mul` at edge 0 with `in_valid` held high carrying jr: `alucontrol` = 6 in cycles 1–3 with `multi` = 1; `in_ready` = 0 in cycles 1–2; `last` only in cycle 3; jr accepted at edge 3 gives 7 in cycle 4.
- `aluop` 00, `funct` 100000: `out_valid` = 1, `illegal` = 1, `alucontrol` = 0. Then `aluop` 01 with `funct` 100000: `illegal` = 0, code 2.
- `flush` in cycle 2 of a `MUL_LAT` = 4 `mul`, with `in_valid` = 1 in the same cycle: `out_valid` = 0 next cycle, state IDLE, that input not accepted; `in_ready` = 1 the cycle after.
- `rst_n` pulsed low asynchronously mid-`mul`: all outputs 0 immediately; after release, accept `aluop` 10 and check `alucontrol` = 3 one cycle later.
- `MUL_LAT` = 1 and `CTRL_W` = 6 build: `mul` gives one valid cycle, `multi` = 1, `last` = 1, `alucontrol` = 6'h06.
